writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
// - Writer side of the 32x32 register file write port (WriteReg/WriteData/RegWrite).
// - Buffers register writebacks from two producers (A: ALU path, B: multi-cycle/load path) in a FIFO.
// - Drains at most one write per cycle into the register file.
// - Optional forwarding lookup returns pending (not yet written) values to the decode stage.
// PARAMETERS
// - DEPTH  4   FIFO entries; power of 2, >=2.
// - AW     5   register address width.
// - DW     32  data width.
// PORTS
// - clk_i        in   1          clock; all state updates on rising edge.
// - rst_i        in   1          reset; synchronous, active-low.
// - a_valid_i    in   1          producer A write request.
// - a_reg_i      in   AW         producer A destination register.
// - a_data_i     in   DW         producer A data.
// - b_valid_i    in   1          producer B write request.
// - b_reg_i      in   AW         producer B destination register.
// - b_data_i     in   DW         producer B data.
// - ready_o      out  1          queue accepts requests this cycle (shared by A and B).
// - RegWrite_o   out  1          write strobe to register file.
// - WriteReg_o   out  AW         write address to register file.
// - WriteData_o  out  DW         write data to register file.
// - count_o      out  log2(DEPTH)+1  occupied entries.
// - lk_reg_i     in   AW         forwarding lookup address (WBQ_FWD_EN only).
// - lk_hit_o     out  1          lookup matched a pending entry.
// - lk_data_o    out  DW         data of youngest matching entry.
// BEHAVIOUR
// - Reset (rst_i=0 at clk edge): FIFO empty, count_o=0, RegWrite_o=0, WriteReg_o=0, WriteData_o=0.
//   lk_hit_o=0 and ready_o=1 after reset.
//   Reset overrides same-cycle enqueue/dequeue; in-flight writes are discarded.
// - ready_o = (DEPTH - count) >= 2, from the registered count only. No pass-through credit for a same-cycle dequeue.
// - Enqueue on edge when ready_o=1 and valid=1.
//   - Both valid in the same cycle: A is written first (older), then B.
//   - Request with reg==0: dropped, never stored; its ready is still honoured.
//   - valid while ready_o=0: ignored. Producer must hold the request until ready_o=1.
// - Dequeue: whenever count>0, the head is presented combinationally.
//   - RegWrite_o=1, WriteReg_o/WriteData_o = head.
//   - Head is popped at the next edge. No backpressure from the register file.
// - Empty: RegWrite_o=0, WriteReg_o=0, WriteData_o=0.
// - Latency: request accepted at edge N appears on RegWrite_o in cycle N+1 if the queue was empty.
//   Otherwise it appears after all older entries.
// - Simultaneous enqueue(s) and dequeue: count_next = count + enq_cnt - 1. Pointers wrap modulo DEPTH.
// - Never overflows: ready_o guarantees space for 2.
//   Underflow is impossible, since a pop only occurs with count>0.
// - Program order is preserved.
//   Two queued writes to the same register are both emitted, oldest first.
// CONFIGURATION
// - WBQ_FWD_EN defined:
//   - lk_hit_o=1 if any stored entry has reg==lk_reg_i and lk_reg_i!=0.
//   - lk_data_o = data of the youngest such entry.
//   - The head entry being written this cycle counts as stored.
//   - Same-cycle a_/b_ requests are NOT searched.
//   - Purely combinational from FIFO state.
// - WBQ_FWD_EN undefined: no comparators; lk_hit_o=0, lk_data_o=0; lk_reg_i unused.
// TESTING
// - Reset: rst_i=0 for 2 cycles with a_valid_i=1 -> count_o=0, RegWrite_o=0, ready_o=1 after release.
// - Single write: A (r5, 0xDEADBEEF) at edge N, queue empty -> cycle N+1 RegWrite_o=1, WriteReg_o=5, WriteData_o=0xDEADBEEF; cycle N+2 RegWrite_o=0.
// - Ordering: same cycle A (r3, 1) and B (r3, 2) -> r3<=1, then r3<=2 on consecutive cycles; lookup r3 -> hit, data 2 while both are pending.
// - r0 drop: A (r0, 0x55) with B (r7, 0x66) -> only r7 is emitted; count_o peaks at 1.
// - Full: hold A+B valid for 3 cycles, DEPTH=4 -> ready_o=0 when count=3; no entry lost; 4 writes drain in order.
// - Config: with WBQ_FWD_EN undefined, a pending r9 and lookup r9 -> lk_hit_o=0, lk_data_o=0.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: buffers register-file writebacks from two producers and drains
// at most one write per cycle into the 32x32 register file write port.
//
// Producer A (ALU path) and producer B (multi-cycle/load path) share one ready_o.
// When both fire in the same cycle, A is treated as older and stored first.
// Requests that target r0 are accepted but never stored.
// The head entry is presented combinationally on RegWrite_o/WriteReg_o/WriteData_o,
// and it is popped on the following edge. The register file applies no backpressure.
//
// Optional feature, enabled by the WBQ_FWD_EN macro: a forwarding lookup. It returns
// the youngest pending value for lk_reg_i, searched over the stored entries
// (including the head). With the macro undefined, lk_hit_o and lk_data_o are tied to 0.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active low
//   a_valid_i    producer A request
//   a_reg_i      producer A destination register
//   a_data_i     producer A data
//   b_valid_i    producer B request
//   b_reg_i      producer B destination register
//   b_data_i     producer B data
//   ready_o      queue accepts requests this cycle (room for two)
//   RegWrite_o   register file write strobe
//   WriteReg_o   register file write address
//   WriteData_o  register file write data
//   count_o      occupied entries
//   lk_reg_i     forwarding lookup address
//   lk_hit_o     lookup matched a pending entry
//   lk_data_o    data of the youngest matching entry
module writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     a_valid_i,
  input  logic [AW-1:0]            a_reg_i,
  input  logic [DW-1:0]            a_data_i,
  input  logic                     b_valid_i,
  input  logic [AW-1:0]            b_reg_i,
  input  logic [DW-1:0]            b_data_i,
  output logic                     ready_o,
  output logic                     RegWrite_o,
  output logic [AW-1:0]            WriteReg_o,
  output logic [DW-1:0]            WriteData_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic [AW-1:0]            lk_reg_i,
  output logic                     lk_hit_o,
  output logic [DW-1:0]            lk_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] reg_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          a_ok, b_ok, deq;
  logic [PW-1:0] b_wr_ptr;
  logic [CW-1:0] enq_cnt;

  // Ready only reflects the registered count, so a full-but-draining queue still
  // stalls producers for one cycle.
  assign ready_o = (count_q <= CW'(DEPTH - 2));

  // r0 requests consume a handshake but are not stored.
  assign a_ok = ready_o & a_valid_i & (a_reg_i != '0);
  assign b_ok = ready_o & b_valid_i & (b_reg_i != '0);
  assign deq  = (count_q != '0);

  // B lands behind A when both are stored, otherwise in A's slot.
  assign b_wr_ptr = wr_ptr_q + PW'(a_ok);
  assign enq_cnt  = CW'(a_ok) + CW'(b_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(enq_cnt);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    count_d  = count_q + enq_cnt - CW'(deq);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (a_ok) begin
        reg_q[wr_ptr_q]  <= a_reg_i;
        data_q[wr_ptr_q] <= a_data_i;
      end
      if (b_ok) begin
        reg_q[b_wr_ptr]  <= b_reg_i;
        data_q[b_wr_ptr] <= b_data_i;
      end
    end
  end

  assign count_o     = count_q;
  assign RegWrite_o  = deq;
  assign WriteReg_o  = deq ? reg_q[rd_ptr_q]  : '0;
  assign WriteData_o = deq ? data_q[rd_ptr_q] : '0;

`ifdef WBQ_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk from the head (oldest) to the tail. Later matches override earlier ones,
  // so the youngest matching entry supplies the data.
  always_comb begin
    lk_hit_o  = 1'b0;
    lk_data_o = '0;
    fwd_idx   = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (lk_reg_i != '0) && (reg_q[fwd_idx] == lk_reg_i)) begin
        lk_hit_o  = 1'b1;
        lk_data_o = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_lk_reg;
  assign unused_lk_reg = ^lk_reg_i;
  assign lk_hit_o      = 1'b0;
  assign lk_data_o     = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed testbench for writeback_queue (DEPTH=4, AW=5, DW=32).
// Lookup expectations depend on whether WBQ_FWD_EN is defined for the build.
module tb_writeback_queue;

`ifdef WBQ_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_valid_i, b_valid_i;
  logic [4:0]  a_reg_i, b_reg_i, lk_reg_i;
  logic [31:0] a_data_i, b_data_i;
  logic        ready_o, RegWrite_o, lk_hit_o;
  logic [4:0]  WriteReg_o;
  logic [31:0] WriteData_o, lk_data_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  writeback_queue #(
    .DEPTH(4),
    .AW   (5),
    .DW   (32)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_valid_i  (a_valid_i),
    .a_reg_i    (a_reg_i),
    .a_data_i   (a_data_i),
    .b_valid_i  (b_valid_i),
    .b_reg_i    (b_reg_i),
    .b_data_i   (b_data_i),
    .ready_o    (ready_o),
    .RegWrite_o (RegWrite_o),
    .WriteReg_o (WriteReg_o),
    .WriteData_o(WriteData_o),
    .count_o    (count_o),
    .lk_reg_i   (lk_reg_i),
    .lk_hit_o   (lk_hit_o),
    .lk_data_o  (lk_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the write port: strobe, address, data and occupancy.
  task automatic check_port(input string tag, input logic we, input logic [4:0] r,
                            input logic [31:0] d, input logic [2:0] cnt);
    check({tag, ".we"},    32'(RegWrite_o),  32'(we));
    check({tag, ".reg"},   32'(WriteReg_o),  32'(r));
    check({tag, ".data"},  WriteData_o,      d);
    check({tag, ".count"}, 32'(count_o),     32'(cnt));
  endtask

  task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    a_valid_i = v; a_reg_i = r; a_data_i = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    b_valid_i = v; b_reg_i = r; b_data_i = d;
  endtask

  initial begin
    rst_i = 1'b0;
    set_a(1'b1, 5'd1, 32'h1111_1111);
    set_b(1'b0, 5'd0, 32'h0);
    lk_reg_i = 5'd0;

    // Reset held two cycles with a request pending
    step();
    step();
    rst_i = 1'b1;
    set_a(1'b0, 5'd0, 32'h0);
    check_port("reset", 1'b0, 5'd0, 32'h0, 3'd0);
    check("reset.ready", 32'(ready_o), 32'd1);
    check("reset.lk_hit", 32'(lk_hit_o), 32'd0);

    // Single write on an empty queue: visible the cycle after acceptance
    set_a(1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    set_a(1'b0, 5'd0, 32'h0);
    lk_reg_i = 5'd5;
    #1;
    check_port("single.n1", 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd1);
    check("single.lk_hit", 32'(lk_hit_o), Fwd ? 32'd1 : 32'd0);
    check("single.lk_data", lk_data_o, Fwd ? 32'hDEAD_BEEF : 32'h0);
    step();
    check_port("single.n2", 1'b0, 5'd0, 32'h0, 3'd0);
    check("single.lk_hit_gone", 32'(lk_hit_o), 32'd0);

    // Same-register ordering: A older than B, lookup returns the younger value
    set_a(1'b1, 5'd3, 32'd1);
    set_b(1'b1, 5'd3, 32'd2);
    lk_reg_i = 5'd3;
    #1;
    check("order.same_cycle_not_searched", 32'(lk_hit_o), 32'd0);
    step();
    set_a(1'b0, 5'd0, 32'h0);
    set_b(1'b0, 5'd0, 32'h0);
    #1;
    check_port("order.first", 1'b1, 5'd3, 32'd1, 3'd2);
    check("order.ready_at_2", 32'(ready_o), 32'd1);
    check("order.lk_hit", 32'(lk_hit_o), Fwd ? 32'd1 : 32'd0);
    check("order.lk_data", lk_data_o, Fwd ? 32'd2 : 32'd0);
    step();
    check_port("order.second", 1'b1, 5'd3, 32'd2, 3'd1);
    check("order.lk_data_head", lk_data_o, Fwd ? 32'd2 : 32'd0);
    step();
    check_port("order.empty", 1'b0, 5'd0, 32'h0, 3'd0);

    // r0 request is dropped; only r7 is stored
    set_a(1'b1, 5'd0, 32'h55);
    set_b(1'b1, 5'd7, 32'h66);
    lk_reg_i = 5'd0;
    step();
    set_a(1'b0, 5'd0, 32'h0);
    set_b(1'b0, 5'd0, 32'h0);
    #1;
    check_port("r0.only_r7", 1'b1, 5'd7, 32'h66, 3'd1);
    check("r0.lk_r0_nohit", 32'(lk_hit_o), 32'd0);
    step();
    check_port("r0.empty", 1'b0, 5'd0, 32'h0, 3'd0);

    // Pending r9 lookup: hit only when forwarding is built in
    set_a(1'b1, 5'd9, 32'h9999);
    step();
    set_a(1'b0, 5'd0, 32'h0);
    lk_reg_i = 5'd9;
    #1;
    check("cfg.lk_hit", 32'(lk_hit_o), Fwd ? 32'd1 : 32'd0);
    check("cfg.lk_data", lk_data_o, Fwd ? 32'h9999 : 32'h0);
    lk_reg_i = 5'd10;
    #1;
    check("cfg.lk_miss", 32'(lk_hit_o), 32'd0);
    step();
    check_port("cfg.empty", 1'b0, 5'd0, 32'h0, 3'd0);

    // Fill: A+B held every cycle, stall at count 3, nothing lost, FIFO order kept
    set_a(1'b1, 5'd1, 32'h11);
    set_b(1'b1, 5'd2, 32'h22);
    step();
    set_a(1'b1, 5'd3, 32'h33);
    set_b(1'b1, 5'd4, 32'h44);
    #1;
    check_port("full.c1", 1'b1, 5'd1, 32'h11, 3'd2);
    check("full.c1.ready", 32'(ready_o), 32'd1);
    step();
    set_a(1'b1, 5'd5, 32'h55);
    set_b(1'b1, 5'd6, 32'h66);
    #1;
    check_port("full.c2", 1'b1, 5'd2, 32'h22, 3'd3);
    check("full.c2.ready", 32'(ready_o), 32'd0);
    step();
    // Request held while ready was low must not have been taken
    check_port("full.c3", 1'b1, 5'd3, 32'h33, 3'd2);
    check("full.c3.ready", 32'(ready_o), 32'd1);
    step();
    set_a(1'b0, 5'd0, 32'h0);
    set_b(1'b0, 5'd0, 32'h0);
    #1;
    check_port("full.c4", 1'b1, 5'd4, 32'h44, 3'd3);
    step();
    check_port("full.c5", 1'b1, 5'd5, 32'h55, 3'd2);
    step();
    check_port("full.c6", 1'b1, 5'd6, 32'h66, 3'd1);
    step();
    check_port("full.drained", 1'b0, 5'd0, 32'h0, 3'd0);
    check("full.drained.ready", 32'(ready_o), 32'd1);

    // Reset discards in-flight entries
    set_a(1'b1, 5'd12, 32'hC0C0);
    set_b(1'b1, 5'd13, 32'hD0D0);
    step();
    rst_i = 1'b0;
    set_a(1'b1, 5'd14, 32'hE0E0);
    set_b(1'b0, 5'd0, 32'h0);
    step();
    rst_i = 1'b1;
    set_a(1'b0, 5'd0, 32'h0);
    #1;
    check_port("rst_flush", 1'b0, 5'd0, 32'h0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
